dac_spi_serializer: RTL and testbench

//  Downstream consumer of the dual sine-wave generator. Captures one (dout1, dout2) sample pair per

---
 rtl/dac_spi_serializer_pkg.sv | 30 +++
 rtl/dac_spi_serializer_if.sv | 31 +++
 rtl/dac_spi_serializer_tick.sv | 28 ++
 rtl/dac_spi_serializer.sv | 184 ++++++++++++++++++
 tb/tb_dac_spi_serializer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_serializer_pkg.sv
// Shared frame layout, FSM state encodings and frame builder for the DAC SPI serializer.
// DAC_LDAC_EN: when defined, the control field requests hold-in-input-register (bit 12 = 0).
package dac_pkg;

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned DAC_W     = 8;
  localparam logic [2:0]  CTRL_BITS = 3'b011;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_SHIFT_A = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_LOAD_B  = 3'd4;
  localparam logic [2:0] ST_SHIFT_B = 3'd5;
  localparam logic [2:0] ST_LDAC    = 3'd6;

  // {chan, buffered, gain, active/update, data[7:0], 4'b0}
  function automatic logic [FRAME_W-1:0] build_frame(input logic chan,
                                                     input logic [DAC_W-1:0] data);
    logic [2:0] ctrl;
    ctrl = CTRL_BITS;
`ifdef DAC_LDAC_EN
    ctrl[0] = 1'b0;
`endif
    return {chan, ctrl, data, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample handshake, status and SPI pins between the sine generator side and the DAC serializer.
// DAC_LDAC_EN: adds the ldac_n strobe.
interface dac_spi_serializer_if #(parameter int unsigned DATA_WIDTH = 8);

  logic                  en;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;

`ifdef DAC_LDAC_EN
  logic                  ldac_n;

  modport master (output en, din1, din2, sample_valid,
                  input  sample_ready, busy, frame_done, overrun, sclk, cs_n, mosi, ldac_n);
  modport slave  (input  en, din1, din2, sample_valid,
                  output sample_ready, busy, frame_done, overrun, sclk, cs_n, mosi, ldac_n);
`else
  modport master (output en, din1, din2, sample_valid,
                  input  sample_ready, busy, frame_done, overrun, sclk, cs_n, mosi);
  modport slave  (input  en, din1, din2, sample_valid,
                  output sample_ready, busy, frame_done, overrun, sclk, cs_n, mosi);
`endif

endinterface

// File: rtl/dac_spi_serializer_tick.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV clocks while run is high.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = i_run && (r_cnt == CNT_W'(CLK_DIV - 1));

  // Counter restarts from zero each time run rises so the first tick lands CLK_DIV cycles in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_serializer.sv
// Captures a (din1, din2) pair and sends it as channel A then channel B 16-bit mode-0 SPI frames.
// DAC_LDAC_EN: adds an ldac_n pulse after channel B and defers frame_done until it ends.
module dac_spi_serializer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dac_spi_serializer_if.slave  bus
);

  localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned BIT_W     = 5;
  localparam logic [BIT_W-1:0] LAST_TICK = 5'd31;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_din1, r_din2, w_din1_nxt, w_din2_nxt;
  logic [FRAME_W-1:0]    r_shift, w_shift_nxt;
  logic [BIT_W-1:0]      r_bit_cnt, w_bit_nxt;
  logic [GAP_W-1:0]      r_gap_cnt, w_gap_nxt;
  logic                  r_sclk, r_cs_n, r_mosi, r_busy, r_frame_done, r_overrun;
  logic                  w_sclk_nxt, w_cs_n_nxt, w_mosi_nxt, w_done_nxt;
  logic                  w_ready, w_accept, w_run, w_tick_c;
  logic [DAC_W-1:0]      w_data1, w_data2;
  logic [FRAME_W-1:0]    w_frame_a, w_frame_b;
`ifdef DAC_LDAC_EN
  logic                  r_ldac_n, w_ldac_n_nxt;
`endif

  // DAC data field is 8 bits: narrower samples are left-justified, wider ones keep their MSBs.
  if (DATA_WIDTH >= DAC_W) begin : g_trunc
    assign w_data1 = r_din1[DATA_WIDTH-1 -: DAC_W];
    assign w_data2 = r_din2[DATA_WIDTH-1 -: DAC_W];
  end else begin : g_pad
    assign w_data1 = {r_din1, {(DAC_W - DATA_WIDTH){1'b0}}};
    assign w_data2 = {r_din2, {(DAC_W - DATA_WIDTH){1'b0}}};
  end

  assign w_frame_a = build_frame(1'b0, w_data1);
  assign w_frame_b = build_frame(1'b1, w_data2);
  assign w_ready   = !rst && (r_state == ST_IDLE) && bus.en;
  assign w_accept  = bus.sample_valid && w_ready;
  assign w_run     = (r_state == ST_SHIFT_A) || (r_state == ST_SHIFT_B) || (r_state == ST_LDAC);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .o_tick_c (w_tick_c)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_din1_nxt  = r_din1;
    w_din2_nxt  = r_din2;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_sclk_nxt  = r_sclk;
    w_cs_n_nxt  = r_cs_n;
    w_mosi_nxt  = r_mosi;
    w_done_nxt  = 1'b0;
`ifdef DAC_LDAC_EN
    w_ldac_n_nxt = 1'b1;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_LOAD_A;
          w_din1_nxt  = bus.din1;
          w_din2_nxt  = bus.din2;
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        w_shift_nxt = (r_state == ST_LOAD_A) ? w_frame_a : w_frame_b;
        w_mosi_nxt  = w_shift_nxt[FRAME_W-1];
        w_cs_n_nxt  = 1'b0;
        w_bit_nxt   = '0;
        w_state_nxt = (r_state == ST_LOAD_A) ? ST_SHIFT_A : ST_SHIFT_B;
      end
      // Even ticks raise sclk; odd ticks lower it and present the next bit; 32nd tick closes the frame.
      ST_SHIFT_A, ST_SHIFT_B: begin
        if (w_tick_c) begin
          w_bit_nxt = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == LAST_TICK) begin
            w_sclk_nxt = 1'b0;
            w_cs_n_nxt = 1'b1;
            if (r_state == ST_SHIFT_A) begin
              w_state_nxt = ST_GAP;
              w_gap_nxt   = '0;
            end else begin
`ifdef DAC_LDAC_EN
              w_state_nxt  = ST_LDAC;
              w_ldac_n_nxt = 1'b0;
              w_bit_nxt    = '0;
`else
              w_state_nxt  = ST_IDLE;
              w_done_nxt   = 1'b1;
`endif
            end
          end else if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt  = 1'b0;
            w_shift_nxt = r_shift << 1;
            w_mosi_nxt  = w_shift_nxt[FRAME_W-1];
          end
        end
      end
      ST_GAP: begin
        w_gap_nxt = r_gap_cnt + GAP_W'(1);
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nxt = ST_LOAD_B;
        end
      end
`ifdef DAC_LDAC_EN
      // ldac_n stays low for two divider ticks, i.e. one full SCLK period.
      ST_LDAC: begin
        w_ldac_n_nxt = 1'b0;
        if (w_tick_c) begin
          w_bit_nxt = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == BIT_W'(1)) begin
            w_ldac_n_nxt = 1'b1;
            w_done_nxt   = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_din1       <= '0;
      r_din2       <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef DAC_LDAC_EN
      r_ldac_n     <= 1'b1;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_din1       <= w_din1_nxt;
      r_din2       <= w_din2_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_sclk       <= w_sclk_nxt;
      r_cs_n       <= w_cs_n_nxt;
      r_mosi       <= w_mosi_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= w_done_nxt;
      r_overrun    <= bus.sample_valid && !w_ready;
`ifdef DAC_LDAC_EN
      r_ldac_n     <= w_ldac_n_nxt;
`endif
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_frame_done;
  assign bus.overrun      = r_overrun;
  assign bus.sclk         = r_sclk;
  assign bus.cs_n         = r_cs_n;
  assign bus.mosi         = r_mosi;
`ifdef DAC_LDAC_EN
  assign bus.ldac_n       = r_ldac_n;
`endif

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer: frame scoreboard on the SPI pins plus latency/handshake checks.
module tb_dac_spi_serializer;

`ifdef DAC_LDAC_EN
  localparam logic BIT12 = 1'b0;
  localparam int   LX0   = 4;
  localparam int   LX1   = 2;
`else
  localparam logic BIT12 = 1'b1;
  localparam int   LX0   = 0;
  localparam int   LX1   = 0;
`endif
  localparam int LAT0 = 132 + LX0;
  localparam int LAT1 = 67 + LX1;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] sb_q[$];

  dac_spi_serializer_if #(.DATA_WIDTH(8)) bus0();
  dac_spi_serializer_if #(.DATA_WIDTH(8)) bus1();

  dac_spi_serializer #(.DATA_WIDTH(8), .CLK_DIV(2), .GAP_CYCLES(2)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  dac_spi_serializer #(.DATA_WIDTH(8), .CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_frame(input logic chan, input logic [7:0] d);
    logic [15:0] f;
    f        = 16'h0000;
    f[15]    = chan;
    f[13]    = 1'b1;
    f[12]    = BIT12;
    f[11:4]  = d;
    return f;
  endfunction

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    sb_q.push_back(exp_frame(1'b0, a));
    sb_q.push_back(exp_frame(1'b1, b));
  endtask

  // SPI monitor on dut0: collect mosi on sclk rises, compare against scoreboard when cs_n rises.
  logic        m_prev_sclk, m_prev_cs;
  logic [15:0] m_acc, m_exp;
  int          m_rises;
  always @(negedge clk) begin
    if (rst) begin
      m_prev_sclk = 1'b0;
      m_prev_cs   = 1'b1;
      m_acc       = '0;
      m_rises     = 0;
    end else begin
      if (m_prev_cs && !bus0.cs_n) begin
        m_acc   = '0;
        m_rises = 0;
      end
      if (!bus0.cs_n && bus0.sclk && !m_prev_sclk) begin
        m_acc = {m_acc[14:0], bus0.mosi};
        m_rises++;
      end
      if (!m_prev_cs && bus0.cs_n) begin
        m_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        check("frame", {16'h0, m_acc}, {16'h0, m_exp});
        check("sclk_rises", m_rises, 16);
        check("sclk_idle", bus0.sclk, 1'b0);
      end
      m_prev_sclk = bus0.sclk;
      m_prev_cs   = bus0.cs_n;
    end
  end

  task automatic tick0();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] a, input logic [7:0] b);
    bus0.din1 = a;
    bus0.din2 = b;
    bus0.sample_valid = 1'b1;
    check("ready_pre", bus0.sample_ready, 1'b1);
    push_pair(a, b);
    tick0();
    bus0.sample_valid = 1'b0;
  endtask

  // Count cycles from capture to frame_done; optionally drop en with valid high at cycle en_off.
  task automatic run0(input string tag, input int en_off);
    int n, first_cs, ldac_low;
    n = 0; first_cs = 0; ldac_low = 0;
    while (n < 300) begin
      tick0();
      n++;
      if (first_cs == 0 && !bus0.cs_n) first_cs = n;
`ifdef DAC_LDAC_EN
      if (!bus0.ldac_n) ldac_low++;
`endif
      if (en_off != 0 && n == en_off) begin
        bus0.en = 1'b0;
        bus0.sample_valid = 1'b1;
      end
      if (bus0.frame_done) break;
    end
    check({tag, "_lat"}, n, LAT0);
    check({tag, "_cs_fall"}, first_cs, 1);
    check({tag, "_busy_end"}, bus0.busy, 1'b0);
`ifdef DAC_LDAC_EN
    check({tag, "_ldac_low"}, ldac_low, 4);
    check({tag, "_ldac_high"}, bus0.ldac_n, 1'b1);
`endif
  endtask

  task automatic drain0();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      tick0();
      k++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    int acc, t, t1, t2, t3, ovr, n, r1, r2;
    logic prev;
    rst = 1'b1;
    bus0.en = 1'b1; bus0.sample_valid = 1'b0; bus0.din1 = '0; bus0.din2 = '0;
    bus1.en = 1'b1; bus1.sample_valid = 1'b0; bus1.din1 = '0; bus1.din2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", bus0.cs_n, 1'b1);
    check("rst_sclk", bus0.sclk, 1'b0);
    check("rst_mosi", bus0.mosi, 1'b0);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_done", bus0.frame_done, 1'b0);
    check("rst_ovr", bus0.overrun, 1'b0);
    check("rst_ready", bus0.sample_ready, 1'b0);
`ifdef DAC_LDAC_EN
    check("rst_ldac", bus0.ldac_n, 1'b1);
`endif
    #2 rst = 1'b0;
    tick0();

    // Single pair A5/3C at CLK_DIV=2
    send0(8'hA5, 8'h3C);
    check("busy_after_cap", bus0.busy, 1'b1);
    run0("t2", 0);
    check("ready_after_done", bus0.sample_ready, 1'b1);
    check("no_overrun", bus0.overrun, 1'b0);
    drain0();

    // Full-scale / zero pattern
    send0(8'hFF, 8'h00);
    run0("t6", 0);
    drain0();

    // CLK_DIV=1, GAP_CYCLES=1 instance
    bus1.din1 = 8'h12; bus1.din2 = 8'h34; bus1.sample_valid = 1'b1;
    check("d1_ready", bus1.sample_ready, 1'b1);
    tick0();
    bus1.sample_valid = 1'b0;
    n = 0; r1 = 0; r2 = 0; prev = 1'b0;
    while (n < 200) begin
      tick0();
      n++;
      if (bus1.sclk && !prev) begin
        if (r1 == 0) r1 = n;
        else if (r2 == 0) r2 = n;
      end
      prev = bus1.sclk;
      if (bus1.frame_done) break;
    end
    check("d1_lat", n, LAT1);
    check("d1_first_rise", r1, 2);
    check("d1_sclk_period", r2 - r1, 2);

    // sample_valid held high: accepts spaced by one full transfer, drops flagged in between
    bus0.en = 1'b1;
    bus0.sample_valid = 1'b1;
    acc = 0; t = 0; t1 = 0; t2 = 0; t3 = 0; ovr = 0;
    while (acc < 3 && t < 600) begin
      bus0.din1 = 8'($urandom);
      bus0.din2 = 8'($urandom);
      if (acc == 1) ovr += int'(bus0.overrun);
      if (bus0.sample_ready) begin
        push_pair(bus0.din1, bus0.din2);
        acc++;
        if (acc == 1) t1 = t;
        else if (acc == 2) t2 = t;
        else t3 = t;
      end
      tick0();
      t++;
    end
    bus0.sample_valid = 1'b0;
    check("accepts", acc, 3);
    check("accept_period1", t2 - t1, LAT0 + 1);
    check("accept_period2", t3 - t2, LAT0 + 1);
    check("overrun_count", ovr, LAT0);
    drain0();

    // en dropped during channel B: transfer completes, no new capture while en=0
    send0(8'hC3, 8'h5A);
    run0("t5", 80);
    check("en0_ready_done", bus0.sample_ready, 1'b0);
    repeat (3) tick0();
    check("en0_ready", bus0.sample_ready, 1'b0);
    check("en0_busy", bus0.busy, 1'b0);
    check("en0_overrun", bus0.overrun, 1'b1);
    bus0.sample_valid = 1'b0;
    bus0.en = 1'b1;
    #1;
    check("en1_ready", bus0.sample_ready, 1'b1);
    drain0();
    tick0();

    // Asynchronous reset in the middle of channel A
    send0(8'hF0, 8'h0F);
    repeat (20) tick0();
    check("pre_rst_cs", bus0.cs_n, 1'b0);
    check("pre_rst_mosi", bus0.mosi, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_cs_n", bus0.cs_n, 1'b1);
    check("arst_sclk", bus0.sclk, 1'b0);
    check("arst_mosi", bus0.mosi, 1'b0);
    check("arst_busy", bus0.busy, 1'b0);
    check("arst_ready", bus0.sample_ready, 1'b0);
    sb_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    tick0();
    check("post_rst_idle", bus0.sample_ready, 1'b1);
    send0(8'h81, 8'h7E);
    run0("post_rst", 0);
    drain0();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
